// File: rtl/out_mem_streamer.sv
// Streams the output pixel RAM as a valid/ready beat stream through a 2-entry skid buffer.
// Optional feature macro: OUT_STREAM_CSUM_EN appends an XOR checksum beat after the last pixel.
module out_mem_streamer #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, STREAM, TAIL, FIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] cnt, addr_q, rd_addr;
    logic              issue, rd_vld, inflight, room, push, pop, push_last;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] buf_data [2];
    logic              buf_last [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        occ;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_data[rd_ptr];
    assign m_last  = buf_last[rd_ptr];
    assign pop     = m_valid && m_ready;
    assign push    = inflight;
    assign busy    = (state == STREAM) || (state == TAIL);
    assign done    = (state == FIN);

    // A read may issue only if its data is guaranteed a slot even if the sink stalls next cycle.
    assign room    = ({1'b0, occ} + {2'b00, inflight} - {2'b00, pop}) <= 3'd1;
    assign rd_addr = (state == IDLE) ? '0 : cnt;
    assign issue   = ((state == IDLE) && start) || ((state == STREAM) && room);
    assign mem_addr = issue ? rd_addr : addr_q;

`ifdef OUT_STREAM_CSUM_EN
    logic              csum_issue, csum_vld, csum_sent;
    logic [DATA_W-1:0] csum;

    assign csum_issue = (state == TAIL) && !csum_sent && room;
    assign inflight   = rd_vld || csum_vld;
    assign push_data  = csum_vld ? csum : mem_rd_data;
    assign push_last  = csum_vld;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            csum      <= '0;
            csum_vld  <= 1'b0;
            csum_sent <= 1'b0;
        end else begin
            csum_vld <= csum_issue;
            if ((state == IDLE) && start) begin
                csum      <= '0;
                csum_sent <= 1'b0;
            end else begin
                if (rd_vld)     csum      <= csum ^ mem_rd_data;
                if (csum_issue) csum_sent <= 1'b1;
            end
        end
    end
`else
    logic rd_last;

    assign inflight  = rd_vld;
    assign push_data = mem_rd_data;
    assign push_last = rd_last;

    always_ff @(posedge clk_50) begin
        if (rst) rd_last <= 1'b0;
        else     rd_last <= issue && (rd_addr == LAST_ADDR);
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (NPIX == 1) ? TAIL : STREAM;
            STREAM:  if (issue && (cnt == LAST_ADDR)) state_nxt = TAIL;
            TAIL:    if (pop && m_last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            rd_vld <= 1'b0;
            occ    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            state  <= state_nxt;
            rd_vld <= issue;
            if (issue) begin
                addr_q <= rd_addr;
                cnt    <= rd_addr + 1'b1;
            end
            if (push) begin
                buf_data[wr_ptr] <= push_data;
                buf_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_out_mem_streamer.sv
// Scoreboard bench for out_mem_streamer: a 64x64 instance for the main frame tests and a 4x2 instance.
module tb_out_mem_streamer;
    localparam int N  = 4096;
    localparam int SN = 8;
`ifdef OUT_STREAM_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, m_ready, m_valid, m_last, busy, done;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rd_data, m_data;
    logic [7:0]  ram [N];

    logic        s_start, s_ready, s_valid, s_last, s_busy, s_done;
    logic [2:0]  s_addr;
    logic [7:0]  s_rd, s_data;
    logic [7:0]  ram_s [SN];

    out_mem_streamer dut (
        .clk_50(clk), .rst(rst), .start(start), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
    );

    out_mem_streamer #(.IMG_W(4), .IMG_H(2), .ADDR_W(3), .DATA_W(8)) dut_s (
        .clk_50(clk), .rst(rst), .start(s_start), .mem_addr(s_addr),
        .mem_rd_data(s_rd), .m_data(s_data), .m_valid(s_valid),
        .m_ready(s_ready), .m_last(s_last), .busy(s_busy), .done(s_done)
    );

    always @(posedge clk) mem_rd_data <= ram[mem_addr];
    always @(posedge clk) s_rd <= ram_s[s_addr];

    int total = 0, bad = 0;
    beat_t q[$], sq[$];
    int beats = 0, frames = 0, s_beats = 0, s_frames = 0, s_addr_chg = 0;
    int rmode = 2;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ready pattern: 0 = always high, 1 = ~30% high, 2 = low
    initial begin
        int mode;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            mode = rmode;
            #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 99) < 30);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // main-instance monitor
    initial begin
        beat_t e;
        bit exp_done = 0, prev_stall = 0, prev_rst = 0;
        logic [7:0] prev_d = '0;
        logic prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_done) begin
                check("done_pulse", done, 1);
                check("busy_low_with_done", busy, 0);
                exp_done = 0;
                frames++;
            end
            if (prev_stall && !prev_rst) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_d);
                check("stall_last", m_last, prev_l);
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected: got data=%0h expected no beat", m_data);
                end else begin
                    e = q.pop_front();
                    check("beat_data", m_data, e.d);
                    check("beat_last", m_last, e.l);
                    if (e.l) exp_done = 1;
                end
                beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
            prev_rst   = rst;
        end
    end

    // small-instance monitor
    initial begin
        beat_t e;
        bit exp_done = 0;
        logic [2:0] prev_a = '0;
        forever begin
            @(negedge clk);
            if (exp_done) begin
                check("s_done_pulse", s_done, 1);
                exp_done = 0;
                s_frames++;
            end
            if (!rst && s_addr !== prev_a) begin
                check("s_addr_step", s_addr, 3'(prev_a + 3'd1));
                s_addr_chg++;
                prev_a = s_addr;
            end
            if (s_valid && s_ready) begin
                if (sq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL s_beat_unexpected: got data=%0h expected no beat", s_data);
                end else begin
                    e = sq.pop_front();
                    check("s_beat_data", s_data, e.d);
                    check("s_beat_last", s_last, e.l);
                    if (e.l) exp_done = 1;
                end
                s_beats++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        logic [7:0] cs = '0;
        for (int i = 0; i < N; i++) begin
            q.push_back(beat_t'{ram[i], (CS == 0) && (i == N - 1)});
            cs = cs ^ ram[i];
        end
        if (CS != 0) q.push_back(beat_t'{cs, 1'b1});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int limit);
        int c = 0;
        while (frames < target && c < limit) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        check("frame_completed", frames >= target, 1);
    endtask

    task automatic wait_beats(input int target, input int limit);
        int c = 0;
        while (beats < target && c < limit) begin
            tick();
            c++;
        end
        check("beat_count_reached", beats >= target, 1);
    endtask

    initial begin
        int nf = 0;
        int b0;
        rst = 1'b1; start = 1'b0; s_start = 1'b0; s_ready = 1'b1;
        for (int i = 0; i < N; i++) ram[i] = 8'(i);
        for (int i = 0; i < SN; i++) ram_s[i] = 8'(8'h10 + i);
        repeat (3) tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // ramp frame, ready high, second start at beat 100 must be ignored
        rmode = 0;
        tick();
        tick();
        push_frame();
        beats = 0;
        pulse_start();
        check("valid_at_start_plus_1", m_valid, 0);
        check("busy_after_start", busy, 1);
        tick();
        check("valid_at_start_plus_2", m_valid, 1);
        check("pixel0_data", m_data, 8'h00);
        wait_beats(100, 200);
        pulse_start();
        nf++;
        wait_frames(nf, 6000);
        check("frame1_beats", beats, N + CS);
        check("frame1_queue_empty", q.size(), 0);

        // random contents, sink ready ~30% of cycles
        for (int i = 0; i < N; i++) ram[i] = 8'((i * 73 + 11) ^ (i >> 5));
        push_frame();
        beats = 0;
        rmode = 1;
        pulse_start();
        nf++;
        wait_frames(nf, 40000);
        check("frame2_beats", beats, N + CS);

        // reset mid-frame at beat 2000, then restart from pixel 0
        rmode = 0;
        tick();
        tick();
        push_frame();
        beats = 0;
        pulse_start();
        wait_beats(2000, 3000);
        rmode = 2;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("after_rst_valid", m_valid, 0);
        check("after_rst_busy", busy, 0);
        q.delete();
        b0 = beats;
        rmode = 0;
        repeat (5) tick();
        check("no_beats_after_rst", beats, b0);
        push_frame();
        beats = 0;
        pulse_start();
        tick();
        check("restart_valid_plus_2", m_valid, 1);
        check("restart_pixel0", m_data, ram[0]);
        nf++;
        wait_frames(nf, 6000);
        check("frame3_beats", beats, N + CS);

`ifdef OUT_STREAM_CSUM_EN
        // 4095 copies of A5 XOR to A5
        for (int i = 0; i < N; i++) ram[i] = (i == 0) ? 8'h00 : 8'hA5;
        for (int i = 0; i < N; i++) q.push_back(beat_t'{ram[i], 1'b0});
        q.push_back(beat_t'{8'hA5, 1'b1});
        beats = 0;
        pulse_start();
        nf++;
        wait_frames(nf, 6000);
        check("csum_frame_beats", beats, N + 1);
`endif

        // 4x2 instance: 8 beats, addresses 0..7
        for (int i = 0; i < SN; i++) sq.push_back(beat_t'{ram_s[i], (CS == 0) && (i == SN - 1)});
        if (CS != 0) sq.push_back(beat_t'{8'h00, 1'b1});
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        begin
            int c = 0;
            while (s_frames < 1 && c < 100) begin
                tick();
                c++;
            end
        end
        check("s_frame_done", s_frames, 1);
        check("s_beats", s_beats, SN + CS);
        check("s_addr_changes", s_addr_chg, 7);
        check("s_addr_final", s_addr, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/out_mem_streamer.md
OUT_MEM_STREAMER -- requirements
Module: out_mem_streamer

Interface
REQ-001 SHALL have parameter IMG_W, default 64, output image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 64, output image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 12, memory address width; IMG_W*IMG_H SHALL be at most 2**ADDR_W.
REQ-004 SHALL have parameter DATA_W, default 8, pixel width.
REQ-005 SHALL have port clk_50  in  1  single clock; every flop uses its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  in  1  one-cycle request to stream the whole output memory.
REQ-008 SHALL have port mem_addr  out  ADDR_W  read address to output pixel RAM.
REQ-009 SHALL have port mem_rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after mem_addr.
REQ-010 SHALL have port m_data  out  DATA_W  stream pixel.
REQ-011 SHALL have port m_valid  out  1  m_data valid.
REQ-012 SHALL have port m_ready  in  1  sink accepts beat when m_valid&&m_ready.
REQ-013 SHALL have port m_last  out  1  marks final beat of frame.
REQ-014 SHALL have port busy  out  1  high from start acceptance to done.
REQ-015 SHALL have port done  out  1  one-cycle pulse after final beat accepted.

Function
REQ-016 SHALL use FSM states IDLE, STREAM, TAIL, FIN; IDLE->STREAM on start; STREAM->TAIL when last address issued; TAIL->FIN when final beat accepted; FIN->IDLE after one cycle.
REQ-017 SHALL ignore start when not in IDLE.
REQ-018 SHALL issue addresses 0..IMG_W*IMG_H-1 ascending, row-major, no skips or repeats.
REQ-019 SHALL assert m_valid with pixel 0 exactly 2 cycles after the start cycle.
REQ-020 SHALL sustain 1 beat per cycle while m_ready stays high.
REQ-021 SHALL hold m_data, m_last and m_valid stable while m_valid&&!m_ready; no pixel lost or duplicated under any m_ready pattern.
REQ-022 SHALL buffer in-flight RAM data in a 2-entry skid buffer so RAM reads stall only when the buffer is full.
REQ-023 SHALL never drop m_valid once raised until that beat is accepted.
REQ-024 SHALL assert m_last only on the beat with index IMG_W*IMG_H-1, or on the checksum beat when REQ-031 applies.
REQ-025 SHALL pulse done in FIN, 1 cycle after the final handshake; busy SHALL fall in the same cycle done is high.
REQ-026 SHALL hold mem_addr at its last value when no read is issued.

Reset
REQ-027 SHALL, on rst high at a clock edge, go to IDLE and clear the address counter and skid buffer.
REQ-028 SHALL reset outputs to m_valid=0, m_last=0, m_data=0, mem_addr=0, busy=0, done=0.
REQ-029 SHALL abort any frame on rst mid-stream with no further beats; a new start after rst restarts at address 0.
REQ-030 SHALL give rst priority over a simultaneous start.

Configuration
REQ-031 With OUT_STREAM_CSUM_EN defined, SHALL append one extra beat after pixel IMG_W*IMG_H-1: the XOR of all frame pixels (DATA_W bits), carrying m_last; that pixel beat then has m_last=0.
REQ-032 Without OUT_STREAM_CSUM_EN, SHALL emit exactly IMG_W*IMG_H beats with no checksum logic present.

Verification
REQ-033 SHALL verify: RAM[i]=i[7:0], m_ready=1, start pulse -> 4096 beats, m_data=i mod 256, m_valid at start+2, m_last on beat 4095, done 1 cycle after.
REQ-034 SHALL verify: m_ready random 30% high, RAM random -> sink captures exactly RAM contents in order; m_data stable during every stall.
REQ-035 SHALL verify: second start mid-frame at beat 100 -> ignored; beat count stays 4096.
REQ-036 SHALL verify: rst at beat 2000 -> m_valid=0 and busy=0 next cycle; a new start restarts from pixel 0.
REQ-037 SHALL verify with OUT_STREAM_CSUM_EN and RAM all 0xA5 except RAM[0]=0x00 -> 4097 beats, final beat 0xA5 with m_last=1.
REQ-038 SHALL verify: IMG_W=4, IMG_H=2 -> 8 beats, mem_addr 0..7, m_last on beat 7.
